// File: rtl/tick_debounce.sv
// Tick-paced debouncer for one asynchronous level input.
// Define TICK_DEBOUNCE_LONG_EN to add the long-hold pulse counter.
module tick_debounce #(
  parameter int unsigned DB_TICKS = 16,
  parameter int unsigned CNT_W    = 8,
  parameter logic        RST_LVL  = 1'b1
`ifdef TICK_DEBOUNCE_LONG_EN
  ,
  parameter int unsigned LONG_TICKS = 2000,
  parameter int unsigned LONG_W     = 12
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_en,
  input  logic din,
  output logic dout,
  output logic rise_p,
  output logic fall_p,
  output logic busy,
  output logic long_p
);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_t;

  localparam state_t RST_ST = RST_LVL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  logic [1:0]       sync_q;
  logic             din_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic             cnt_last;

  // Sync flops preload the idle level so release never fakes an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{RST_LVL}};
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign din_s    = sync_q[1];
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      dout_q  <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        STABLE_LO: begin
          if (din_s) begin
            state_q <= CHK_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        STABLE_HI: begin
          if (!din_s) begin
            state_q <= CHK_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CHK_HI: begin
          if (!din_s) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tick_en) begin
            if (cnt_last) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
              dout_q  <= 1'b1;
              rise_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CHK_LO: begin
          if (din_s) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tick_en) begin
            if (cnt_last) begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
              dout_q  <= 1'b0;
              fall_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= RST_ST;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout   = dout_q;
  assign rise_p = rise_q;
  assign fall_p = fall_q;
  assign busy   = busy_q;

`ifdef TICK_DEBOUNCE_LONG_EN
  localparam logic [LONG_W-1:0] LONG_END = LONG_W'(LONG_TICKS);

  logic [LONG_W-1:0] lcnt_q;
  logic              long_q;

  // Saturation at LONG_END is what stops a repeat pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (dout_q == RST_LVL) begin
        lcnt_q <= '0;
      end else if (tick_en && (lcnt_q != LONG_END)) begin
        lcnt_q <= lcnt_q + 1'b1;
        long_q <= (lcnt_q == LONG_END - 1'b1);
      end
    end
  end

  assign long_p = long_q;
`else
  assign long_p = 1'b0;
`endif

endmodule

// File: tb/tb_tick_debounce.sv
// Directed bench for tick_debounce: DB_TICKS=4, idle-high, tick every 10 clk.
// Long-hold checks use LONG_TICKS=8 when TICK_DEBOUNCE_LONG_EN is defined.
module tb_tick_debounce;

`ifdef TICK_DEBOUNCE_LONG_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic tick_en;
  logic din;
  logic dout;
  logic rise_p;
  logic fall_p;
  logic busy;
  logic long_p;

  int total = 0;
  int npass = 0;
  int nrise = 0;
  int nfall = 0;
  int nlong = 0;

  tick_debounce #(
    .DB_TICKS (4),
    .CNT_W    (8),
    .RST_LVL  (1'b1)
`ifdef TICK_DEBOUNCE_LONG_EN
    ,
    .LONG_TICKS (8),
    .LONG_W     (12)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_en (tick_en),
    .din     (din),
    .dout    (dout),
    .rise_p  (rise_p),
    .fall_p  (fall_p),
    .busy    (busy),
    .long_p  (long_p)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rise_p) nrise++;
    if (fall_p) nfall++;
    if (long_p) nlong++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_period();
    tick_en = 1'b0;
    repeat (9) cycle();
    tick_en = 1'b1;
    cycle();
    tick_en = 1'b0;
  endtask

  // Drive din to lvl and step the 3 clk until the FSM enters CHK
  task automatic start_chk(input logic lvl, input string tag);
    din = lvl;
    cycle();
    cycle();
    check({tag, "_busy_pre"}, int'(busy), 0);
    cycle();
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  initial begin
    reset_n = 1'b0;
    tick_en = 1'b0;
    din     = 1'b0;

    // reset with din toggling
    for (int i = 0; i < 4; i++) begin
      cycle();
      din = ~din;
      check("rst_dout", int'(dout), 1);
      check("rst_pulses", int'(rise_p | fall_p | busy | long_p), 0);
    end
    din = 1'b1;
    cycle();
    cycle();
    reset_n = 1'b1;
    repeat (5) cycle();
    check("rel_dout", int'(dout), 1);
    check("rel_busy", int'(busy), 0);
    check("rel_rise", nrise, 0);
    check("rel_fall", nfall, 0);

    // glitch: low for 2 ticks then high
    start_chk(1'b0, "gl");
    tick_period();
    tick_period();
    check("gl_dout_mid", int'(dout), 1);
    din = 1'b1;
    cycle();
    cycle();
    check("gl_busy_hold", int'(busy), 1);
    cycle();
    check("gl_busy_end", int'(busy), 0);
    check("gl_dout", int'(dout), 1);
    check("gl_fall", nfall, 0);

    // race: din_s back to 1 on the 4th tick clk
    start_chk(1'b0, "rc");
    tick_period();
    tick_period();
    tick_period();
    tick_en = 1'b0;
    repeat (7) cycle();
    din = 1'b1;
    cycle();
    cycle();
    tick_en = 1'b1;
    cycle();
    tick_en = 1'b0;
    check("rc_dout", int'(dout), 1);
    check("rc_fall_p", int'(fall_p), 0);
    check("rc_busy", int'(busy), 0);
    repeat (3) cycle();
    check("rc_fall", nfall, 0);

    // clean press
    start_chk(1'b0, "pr");
    tick_period();
    tick_period();
    tick_period();
    check("pr_dout_t3", int'(dout), 1);
    check("pr_busy_t3", int'(busy), 1);
    tick_period();
    check("pr_dout_t4", int'(dout), 0);
    check("pr_fall_p", int'(fall_p), 1);
    check("pr_busy_t4", int'(busy), 0);
    cycle();
    check("pr_fall_end", int'(fall_p), 0);
    check("pr_fall_cnt", nfall, 1);

    // release
    start_chk(1'b1, "rl");
    repeat (3) tick_period();
    check("rl_dout_t3", int'(dout), 0);
    tick_period();
    check("rl_dout_t4", int'(dout), 1);
    check("rl_rise_p", int'(rise_p), 1);
    cycle();
    check("rl_rise_cnt", nrise, 1);

    // reset in the middle of a qualification
    start_chk(1'b0, "mr");
    tick_period();
    tick_period();
    reset_n = 1'b0;
    #1;
    check("mr_dout", int'(dout), 1);
    check("mr_busy", int'(busy), 0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();
    check("mr_busy_pre", int'(busy), 0);
    cycle();
    check("mr_busy_re", int'(busy), 1);
    repeat (3) tick_period();
    check("mr_dout_t3", int'(dout), 1);
    tick_period();
    check("mr_dout_t4", int'(dout), 0);
    check("mr_fall_p", int'(fall_p), 1);
    cycle();
    check("mr_fall_cnt", nfall, 2);

    // long hold (8 ticks after fall_p when enabled)
    repeat (7) tick_period();
    check("lg_t7", int'(long_p), 0);
    tick_period();
    check("lg_t8", int'(long_p), int'(LONG_ON));
    cycle();
    check("lg_end", int'(long_p), 0);
    repeat (3) tick_period();
    check("lg_cnt", nlong, int'(LONG_ON));

    start_chk(1'b1, "lr");
    repeat (4) tick_period();
    check("lr_dout", int'(dout), 1);
    check("lr_rise_p", int'(rise_p), 1);
    cycle();
    check("fin_rise", nrise, 2);
    check("fin_fall", nfall, 2);
    check("fin_long", nlong, int'(LONG_ON));

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
